res_splitter: RTL and testbench
===============================

// Module: res_splitter
// PURPOSE
//  Residual-path source: forks the activation stream of a layer into the main path (to the next
//  layer's conv engine) and, for residual-producing layers, a copy into the residual stream that
//  later feeds the residual adder's int2res input. One 1-bit instruction per layer selects
//  fork/no-fork; the layer ends on a beat with tlast & tuser.
// PARAMETERS
//  AXI_DATA_WIDTH  `DFLT_CORE_AXI_DATA_WIDTH (128)  stream data width; tkeep is AXI_DATA_WIDTH/8
//  CNT_WIDTH       16                               width of each status counter field
// PORTS
//  clk                      in   1      single clock for all logic
//  rst                      in   1      reset: asynchronous, active-high
//  status                   out  32     [31:16] layers completed, [15:0] instructions accepted
//  s_axis_split_instr_tready out 1      instruction accept
//  s_axis_split_instr_tvalid in  1      instruction valid
//  s_axis_split_instr_tdata in   1      0 = main only, 1 = main + residual copy
//  s_axis_src_tready        out  1      source stream accept
//  s_axis_src_tvalid/tdata/tkeep/tlast/tuser  in  1/W/W/8/1/1  source beat; tuser marks layer-last
//  m_axis_main_tready       in   1      main branch ready
//  m_axis_main_tvalid/tdata/tkeep/tlast/tuser out 1/W/W/8/1/1  main branch beat
//  m_axis_res_tready        in   1      residual branch ready
//  m_axis_res_tvalid/tdata/tkeep/tlast out 1/W/W/8/1           residual branch beat (no tuser)
// BEHAVIOUR
//  - Decided: one clock; reset is asynchronous and active-high.
//  - Reset: state=IDLE, res_en=0, main_pend=0, res_pend=0, data/keep/last/user regs=0, status=0;
//    all outputs low/zero. Reset mid-layer discards any held beat; no partial completion counted.
//  - FSM IDLE -> RUN on instr handshake (latch res_en=tdata); RUN -> DRAIN on accepted src beat with
//    tlast&tuser; DRAIN -> IDLE when main_pend and res_pend are both 0 (incl. cleared this cycle).
//  - instr_tready = (state==IDLE). src_tready = (state==RUN) & main_free & res_free, where
//    main_free = ~main_pend | main handshake, res_free = ~res_pend | res handshake (this cycle).
//  - On src accept: load shared data/keep/last/user register; main_pend<=1; res_pend<=res_en.
//    Else a branch handshake clears its pend flag. Latency 1 cycle; 1 beat/cycle when both ready.
//  - m_axis_main_tvalid = main_pend; m_axis_res_tvalid = res_pend; both branches show the same
//    register contents. Branches drain independently; next src beat waits until both are free.
//  - res_en=0: m_axis_res_tvalid never asserts; res_tready ignored.
//  - src beats offered in IDLE/DRAIN are not accepted (tready=0), never dropped.
//  - Counters: instr field +1 per instr handshake; layer field +1 on DRAIN->IDLE; both wrap mod 2^16.
// CONFIGURATION
//  - RES_SPLITTER_STATUS_EN defined: status counters implemented as above.
//  - Not defined: counters omitted, status tied to 32'h0; datapath and FSM unchanged.
// STRUCTURE
//  - Shared package res_pkg: typedef enum logic [1:0] {RS_IDLE, RS_RUN, RS_DRAIN} res_split_state_t;
//    localparam RES_INSTR_FORK = 1'b1.
//  - One sub-module res_bcast_reg: one-entry register with two pend flags and per-branch
//    valid/ready; FSM and counters stay in res_splitter.
// TESTING
//  1 instr=1, 4 beats (last beat tlast=tuser=1), both readies high -> 4 beats on each branch,
//    identical tdata/tkeep/tlast, src_tready high each RUN cycle, status=32'h0001_0001 after drain.
//  2 instr=0, 3 beats -> main gets 3 beats, res_tvalid stays 0 while res_tready toggles.
//  3 instr=1, res_tready low 5 cycles, main ready -> main takes beat 0, src_tready low until res
//    takes beat 0; no beat lost or duplicated on either branch.
//  4 second instr offered during RUN/DRAIN -> instr_tready=0 until DRAIN->IDLE, then accepted.
//  5 rst pulse mid-layer with main_pend=1 -> all valids 0 immediately (async), state IDLE, status 0.
//  6 build without RES_SPLITTER_STATUS_EN, rerun scenario 1 -> same streams, status=32'h0.

Source files
------------

// File: rtl/res_splitter_pkg.sv
// Shared types and constants for the residual-path splitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`ifndef DFLT_CORE_AXI_DATA_WIDTH
`define DFLT_CORE_AXI_DATA_WIDTH 128
`endif

package res_pkg;
    typedef enum logic [1:0] {RS_IDLE, RS_RUN, RS_DRAIN} res_split_state_t;
    localparam logic RES_INSTR_FORK = 1'b1;
endpackage

// File: rtl/res_splitter_if.sv
// AXI-stream beat bundle shared by the splitter source and both branches.
// Latency: n/a (wires only).
// Backpressure: tready driven by the slave side.
interface res_splitter_if #(
    parameter int W = 128
) ();
    logic           tvalid;
    logic           tready;
    logic [W-1:0]   tdata;
    logic [W/8-1:0] tkeep;
    logic           tlast;
    logic           tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/res_splitter_bcast.sv
// One-entry broadcast register: a single held beat presented to two branches with own pend flags.
// Latency: 1 cycle from load to valid on both branches.
// Backpressure: a branch is free when empty or handshaking this cycle; load only when both free.
module res_bcast_reg #(
    parameter int W = 128
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld_vld,
    input  logic           ld_res,
    input  logic [W-1:0]   ld_dat,
    input  logic [W/8-1:0] ld_keep,
    input  logic           ld_last,
    input  logic           ld_user,
    input  logic           main_rdy,
    input  logic           res_rdy,
    output logic           main_vld,
    output logic           res_vld,
    output logic           main_free,
    output logic           res_free,
    output logic [W-1:0]   q_dat,
    output logic [W/8-1:0] q_keep,
    output logic           q_last,
    output logic           q_user
);
    logic main_pend;
    logic res_pend;

    assign main_vld  = main_pend;
    assign res_vld   = res_pend;
    assign main_free = ~main_pend | main_rdy;
    assign res_free  = ~res_pend | res_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_pend <= 1'b0;
            res_pend  <= 1'b0;
            q_dat     <= '0;
            q_keep    <= '0;
            q_last    <= 1'b0;
            q_user    <= 1'b0;
        end else if (ld_vld) begin
            main_pend <= 1'b1;
            res_pend  <= ld_res;
            q_dat     <= ld_dat;
            q_keep    <= ld_keep;
            q_last    <= ld_last;
            q_user    <= ld_user;
        end else begin
            // Branches drain independently; each clears only on its own handshake.
            if (main_pend && main_rdy) main_pend <= 1'b0;
            if (res_pend && res_rdy)   res_pend  <= 1'b0;
        end
    end
endmodule

// File: rtl/res_splitter.sv
// Forks a layer's activation stream to the main path and optionally a residual copy; RES_SPLITTER_STATUS_EN adds status counters.
// Latency: 1 cycle src->branches; 1 beat/cycle when both branches ready.
// Backpressure: src stalls until every pending branch has taken the held beat; instr accepted only in IDLE.
module res_splitter
    import res_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = `DFLT_CORE_AXI_DATA_WIDTH,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                clk,
    input  logic                rst,
    output logic [31:0]         status,
    output logic                s_axis_split_instr_tready,
    input  logic                s_axis_split_instr_tvalid,
    input  logic                s_axis_split_instr_tdata,
    res_splitter_if.slave       s_axis_src,
    res_splitter_if.master      m_axis_main,
    res_splitter_if.master      m_axis_res
);
    res_split_state_t state, state_nxt;
    logic res_en;
    logic main_free, res_free;
    logic src_hs, instr_hs, layer_done;

    assign instr_hs = s_axis_split_instr_tvalid & s_axis_split_instr_tready;
    assign src_hs   = s_axis_src.tvalid & s_axis_src.tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RS_IDLE;
            res_en <= 1'b0;
        end else begin
            state <= state_nxt;
            if (instr_hs) res_en <= (s_axis_split_instr_tdata == RES_INSTR_FORK);
        end
    end

    always_comb begin
        state_nxt                 = state;
        layer_done                = 1'b0;
        s_axis_split_instr_tready = (state == RS_IDLE);
        s_axis_src.tready         = (state == RS_RUN) & main_free & res_free;
        case (state)
            RS_IDLE:  if (s_axis_split_instr_tvalid) state_nxt = RS_RUN;
            RS_RUN:   if (src_hs && s_axis_src.tlast && s_axis_src.tuser) state_nxt = RS_DRAIN;
            // No loads happen in DRAIN, so "free" means the flag is clear after this edge.
            RS_DRAIN: if (main_free && res_free) begin
                state_nxt  = RS_IDLE;
                layer_done = 1'b1;
            end
            default:  state_nxt = RS_IDLE;
        endcase
    end

    res_bcast_reg #(.W(AXI_DATA_WIDTH)) u_bcast (
        .clk       (clk),
        .rst       (rst),
        .ld_vld    (src_hs),
        .ld_res    (res_en),
        .ld_dat    (s_axis_src.tdata),
        .ld_keep   (s_axis_src.tkeep),
        .ld_last   (s_axis_src.tlast),
        .ld_user   (s_axis_src.tuser),
        .main_rdy  (m_axis_main.tready),
        .res_rdy   (m_axis_res.tready),
        .main_vld  (m_axis_main.tvalid),
        .res_vld   (m_axis_res.tvalid),
        .main_free (main_free),
        .res_free  (res_free),
        .q_dat     (m_axis_main.tdata),
        .q_keep    (m_axis_main.tkeep),
        .q_last    (m_axis_main.tlast),
        .q_user    (m_axis_main.tuser)
    );

    assign m_axis_res.tdata = m_axis_main.tdata;
    assign m_axis_res.tkeep = m_axis_main.tkeep;
    assign m_axis_res.tlast = m_axis_main.tlast;
    assign m_axis_res.tuser = 1'b0;

`ifdef RES_SPLITTER_STATUS_EN
    logic [CNT_WIDTH-1:0] instr_cnt, layer_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_cnt <= '0;
            layer_cnt <= '0;
        end else begin
            if (instr_hs)   instr_cnt <= instr_cnt + 1'b1;
            if (layer_done) layer_cnt <= layer_cnt + 1'b1;
        end
    end

    assign status = {layer_cnt, instr_cnt};
`else
    logic unused_done;
    assign unused_done = layer_done;
    assign status      = 32'h0;
`endif
endmodule

// File: tb/tb_res_splitter.sv
// Randomized scoreboard bench for res_splitter: expected beats queued at source acceptance, popped by a monitor.
module tb_res_splitter;
    localparam int W = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] status;
    logic        instr_rdy, instr_vld, instr_dat;

    res_splitter_if #(.W(W)) src_if ();
    res_splitter_if #(.W(W)) main_if ();
    res_splitter_if #(.W(W)) res_if ();

    res_splitter #(.AXI_DATA_WIDTH(W), .CNT_WIDTH(16)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .status                    (status),
        .s_axis_split_instr_tready (instr_rdy),
        .s_axis_split_instr_tvalid (instr_vld),
        .s_axis_split_instr_tdata  (instr_dat),
        .s_axis_src                (src_if),
        .m_axis_main               (main_if),
        .m_axis_res                (res_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   d;
        logic [W/8-1:0] k;
        logic           l;
        logic           u;
    } beat_t;

    beat_t main_q[$];
    beat_t res_q[$];
    int total = 0;
    int bad   = 0;
    int mode  = 0;
    int res_hold = 0;
    int n_instr = 0;
    int n_layer = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
`ifdef RES_SPLITTER_STATUS_EN
        logic [15:0] li, ll;
        li = n_instr[15:0];
        ll = n_layer[15:0];
        return {ll, li};
`else
        return 32'h0;
`endif
    endfunction

    // Branch ready generator: all-ready, random, residual held low for a while, or all stalled.
    initial forever begin
        @(negedge clk);
        case (mode)
            0: begin main_if.tready = 1'b1; res_if.tready = 1'b1; end
            1: begin main_if.tready = 1'($urandom_range(0, 1)); res_if.tready = 1'($urandom_range(0, 1)); end
            2: begin
                main_if.tready = 1'b1;
                res_if.tready  = (res_hold > 0) ? 1'b0 : 1'b1;
                if (res_hold > 0) res_hold--;
            end
            default: begin main_if.tready = 1'b0; res_if.tready = 1'b0; end
        endcase
    end

    // Monitor: pops the expected beat whenever a branch handshake will occur at the next edge.
    initial forever begin
        beat_t e;
        @(negedge clk);
        #2;
        if (!rst) begin
            if (main_if.tvalid && main_if.tready) begin
                if (main_q.size() == 0) chk("main_extra_beat", 160'd1, 160'd0);
                else begin
                    e = main_q.pop_front();
                    chk("main_beat", {main_if.tdata, main_if.tkeep, main_if.tlast, main_if.tuser},
                        {e.d, e.k, e.l, e.u});
                end
            end
            if (res_if.tvalid) begin
                if (res_q.size() == 0) chk("res_unexpected_valid", 160'd1, 160'd0);
                else if (res_if.tready) begin
                    e = res_q.pop_front();
                    chk("res_beat", {res_if.tdata, res_if.tkeep, res_if.tlast}, {e.d, e.k, e.l});
                end
            end
        end
    end

    task automatic do_instr(input logic f);
        int waits = 0;
        @(negedge clk);
        instr_vld = 1'b1;
        instr_dat = f;
        src_if.tvalid = 1'b1;
        src_if.tdata  = '1;
        #1;
        chk("src_rdy_idle", 160'(src_if.tready), 160'd0);
        while (!instr_rdy && waits < 200) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!instr_rdy) chk("instr_timeout", 160'd1, 160'd0);
        else n_instr++;
        @(posedge clk);
        #1;
        instr_vld = 1'b0;
        src_if.tvalid = 1'b0;
    endtask

    task automatic send_beats(input int n, input logic f, input logic end_layer);
        beat_t b;
        int waits;
        for (int i = 0; i < n; i++) begin
            if (mode == 1) repeat ($urandom_range(0, 2)) @(negedge clk);
            @(negedge clk);
            b.d = {$urandom, $urandom, $urandom, $urandom};
            b.k = 16'($urandom);
            b.l = (end_layer && i == n - 1) ? 1'b1 : 1'($urandom_range(0, 1));
            b.u = (end_layer && i == n - 1) ? 1'b1 : 1'b0;
            src_if.tvalid = 1'b1;
            src_if.tdata  = b.d;
            src_if.tkeep  = b.k;
            src_if.tlast  = b.l;
            src_if.tuser  = b.u;
            #1;
            waits = 0;
            while (!src_if.tready && waits < 200) begin
                @(negedge clk);
                #1;
                waits++;
            end
            if (!src_if.tready) chk("src_timeout", 160'd1, 160'd0);
            else begin
                main_q.push_back(b);
                if (f) res_q.push_back(b);
                chk("instr_rdy_in_run", 160'(instr_rdy), 160'd0);
                if (mode == 0) chk("src_stall_all_ready", 160'(waits), 160'd0);
            end
            @(posedge clk);
            #1;
            src_if.tvalid = 1'b0;
        end
    endtask

    task automatic layer(input logic f, input int n);
        int waits = 0;
        do_instr(f);
        send_beats(n, f, 1'b1);
        @(negedge clk);
        #1;
        while (!instr_rdy && waits < 200) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (!instr_rdy) chk("drain_timeout", 160'd1, 160'd0);
        else n_layer++;
        chk("status_after_layer", 160'(status), 160'(exp_status()));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        instr_vld = 1'b0;
        instr_dat = 1'b0;
        src_if.tvalid = 1'b0;
        src_if.tdata  = '0;
        src_if.tkeep  = '0;
        src_if.tlast  = 1'b0;
        src_if.tuser  = 1'b0;
        main_if.tready = 1'b1;
        res_if.tready  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_status", 160'(status), 160'd0);
        chk("rst_main_vld", 160'(main_if.tvalid), 160'd0);
        chk("rst_res_vld", 160'(res_if.tvalid), 160'd0);
        chk("rst_src_rdy", 160'(src_if.tready), 160'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_instr_rdy", 160'(instr_rdy), 160'd1);

        mode = 0; layer(1'b1, 4);
        mode = 1; layer(1'b0, 3);
        mode = 2; res_hold = 5; layer(1'b1, 3);
        mode = 1;
        for (int i = 0; i < 8; i++) layer(1'($urandom_range(0, 1)), int'($urandom_range(1, 6)));

        // Reset while a beat is held on a stalled main branch.
        mode = 3;
        do_instr(1'b1);
        send_beats(1, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("pre_rst_main_vld", 160'(main_if.tvalid), 160'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_main_vld", 160'(main_if.tvalid), 160'd0);
        chk("async_rst_res_vld", 160'(res_if.tvalid), 160'd0);
        chk("async_rst_status", 160'(status), 160'd0);
        chk("async_rst_idle", 160'(instr_rdy), 160'd1);
        main_q.delete();
        res_q.delete();
        n_instr = 0;
        n_layer = 0;
        @(negedge clk);
        rst = 1'b0;
        mode = 0;
        layer(1'b1, 4);

        repeat (4) @(negedge clk);
        chk("main_q_empty", 160'(main_q.size()), 160'd0);
        chk("res_q_empty", 160'(res_q.size()), 160'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
